rf_wb_arbiter: RTL and testbench

- Write-back arbiter and scoreboard in front of the 32 x XLEN register file.
- Shares the register file's single write port between two producers: requester 0 (ALU) and requester 1 (load/memory unit).
- Uses round-robin arbitration and a registered output stage.
- Keeps a pending-write bitmap so the issue stage can detect RAW hazards on rs1/rs2.

---
 rtl/rf_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the register file.
// Two producers (0 = ALU, 1 = load unit) share the single write port under
// round-robin arbitration; the winning write is registered before it reaches
// the register file. A pending bitmap tracks issued-but-unwritten destinations
// so the issue stage can detect RAW hazards on its source operands.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int SELW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SELW-1:0] req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SELW-1:0] req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            rf_wr,
    output logic [SELW-1:0] rf_selwr,
    output logic [XLEN-1:0] rf_in,
    input  logic            issue_valid,
    input  logic [SELW-1:0] issue_rd,
    input  logic [SELW-1:0] chk_rs1,
    input  logic [SELW-1:0] chk_rs2,
    output logic            chk_hazard,
    output logic [NREG-1:0] pending
);

    // One-hot decode of a register selector into a bitmap position.
    function automatic logic [NREG-1:0] rd_mask(input logic [SELW-1:0] rd);
        logic [NREG-1:0] mask;
        mask     = '0;
        mask[rd] = 1'b1;
        return mask;
    endfunction

    // Round-robin memory: 1'b1 means requester 1 won the most recent grant,
    // so requester 0 takes the next contention.
    logic            last_grant_r;

    logic            grant0_s;
    logic            grant1_s;
    logic            any_grant_s;
    logic [SELW-1:0] sel_rd_s;
    logic [XLEN-1:0] sel_data_s;

    logic            rf_wr_r;
    logic [SELW-1:0] rf_selwr_r;
    logic [XLEN-1:0] rf_in_r;

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] pending_next_s;

    // Arbitration: a lone requester wins; on contention the one that did not
    // win last time wins. Nothing is granted while reset is asserted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case ({req1_valid, req0_valid})
                2'b01: grant0_s = 1'b1;
                2'b10: grant1_s = 1'b1;
                2'b11: begin
                    if (last_grant_r) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end
    end

    // Select the winning requester's destination and data.
    always_comb begin
        any_grant_s = grant0_s | grant1_s;
        sel_rd_s    = '0;
        sel_data_s  = '0;
        if (grant1_s) begin
            sel_rd_s   = req1_rd;
            sel_data_s = req1_data;
        end else begin
            sel_rd_s   = req0_rd;
            sel_data_s = req0_data;
        end
    end

    // Remember which requester won, only when something was granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= 1'b1;
        end else if (grant0_s) begin
            last_grant_r <= 1'b0;
        end else if (grant1_s) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Output stage: load a granted write; writes to x0 are accepted but never
    // reach the register file. Selector and data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wr_r    <= 1'b0;
            rf_selwr_r <= '0;
            rf_in_r    <= '0;
        end else if (any_grant_s && (sel_rd_s != '0)) begin
            rf_wr_r    <= 1'b1;
            rf_selwr_r <= sel_rd_s;
            rf_in_r    <= sel_data_s;
        end else begin
            rf_wr_r    <= 1'b0;
            rf_selwr_r <= rf_selwr_r;
            rf_in_r    <= rf_in_r;
        end
    end

    // Scoreboard update: issue sets, the register-file write clears, and a
    // simultaneous set wins because it marks a newer outstanding producer.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (issue_valid && (issue_rd != '0)) begin
            set_mask_s = rd_mask(issue_rd);
        end else begin
            set_mask_s = '0;
        end
        if (rf_wr_r) begin
            clr_mask_s = rd_mask(rf_selwr_r);
        end else begin
            clr_mask_s = '0;
        end
        pending_next_s    = (pending_r & ~clr_mask_s) | set_mask_s;
        pending_next_s[0] = 1'b0;
    end

    // Pending-write bitmap register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rf_wr      = rf_wr_r;
    assign rf_selwr   = rf_selwr_r;
    assign rf_in      = rf_in_r;
    assign pending    = pending_r;
    // Hazard looks at the committed bitmap only; no bypass from the output stage.
    assign chk_hazard = pending_r[chk_rs1] | pending_r[chk_rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset values, single and contended
// write-backs, x0 writes, scoreboard set/clear and asynchronous reset.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        rf_wr;
    logic [4:0]  rf_selwr;
    logic [31:0] rf_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_hazard;
    logic [31:0] pending;

    int n_checks_r;
    int n_pass_r;

    rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .rf_wr      (rf_wr),
        .rf_selwr   (rf_selwr),
        .rf_in      (rf_in),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_hazard (chk_hazard),
        .pending    (pending)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks_r++;
        if (obs === exp) begin
            n_pass_r++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        n_checks_r  = 0;
        n_pass_r    = 0;
        rst         = 1'b0;
        req0_valid  = 1'b1;
        req0_rd     = 5'd5;
        req0_data   = 32'hDEADBEEF;
        req1_valid  = 1'b0;
        req1_rd     = 5'd0;
        req1_data   = 32'h0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        chk_rs1     = 5'd0;
        chk_rs2     = 5'd0;

        // Reset state, with a request already pending.
        #3;
        check_eq("rst_rf_wr",    64'(rf_wr),      64'd0);
        check_eq("rst_selwr",    64'(rf_selwr),   64'd0);
        check_eq("rst_rf_in",    64'(rf_in),      64'd0);
        check_eq("rst_pending",  64'(pending),    64'd0);
        check_eq("rst_ready0",   64'(req0_ready), 64'd0);

        // Single write from requester 0 after release.
        #9 rst = 1'b1;            // t=12, mid-cycle
        #1;
        check_eq("t1_ready0",    64'(req0_ready), 64'd1);
        check_eq("t1_ready1",    64'(req1_ready), 64'd0);
        step();                   // t=16
        req0_valid = 1'b0;
        check_eq("t1_rf_wr",     64'(rf_wr),      64'd1);
        check_eq("t1_selwr",     64'(rf_selwr),   64'd5);
        check_eq("t1_rf_in",     64'(rf_in),      64'hDEADBEEF);
        step();
        check_eq("t1_idle_wr",   64'(rf_wr),      64'd0);
        check_eq("t1_hold_sel",  64'(rf_selwr),   64'd5);
        check_eq("t1_hold_in",   64'(rf_in),      64'hDEADBEEF);

        // Write to x0 from requester 1: handshake completes, no RF write.
        req1_valid = 1'b1;
        req1_rd    = 5'd0;
        req1_data  = 32'h55;
        #1;
        check_eq("x0_ready1",    64'(req1_ready), 64'd1);
        check_eq("x0_ready0",    64'(req0_ready), 64'd0);
        step();
        req1_valid = 1'b0;
        check_eq("x0_rf_wr",     64'(rf_wr),      64'd0);
        check_eq("x0_pending",   64'(pending),    64'd0);

        // Continuous contention: last winner was requester 1, so 0,1,0,1.
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_ready0_%0d", i), 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check_eq($sformatf("rr_ready1_%0d", i), 64'(req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            step();
            check_eq($sformatf("rr_selwr_%0d", i),  64'(rf_selwr),   (i % 2 == 0) ? 64'd1 : 64'd2);
            check_eq($sformatf("rr_rf_in_%0d", i),  64'(rf_in),      (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check_eq("rr_idle_wr",   64'(rf_wr),      64'd0);

        // Scoreboard: issue rd=7, write it back two cycles later.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        chk_rs1     = 5'd7;
        #1;
        check_eq("sb_haz_pre",   64'(chk_hazard), 64'd0);
        step();
        issue_valid = 1'b0;
        check_eq("sb_pend_set",  64'(pending),    64'h80);
        check_eq("sb_haz_set",   64'(chk_hazard), 64'd1);
        step();
        check_eq("sb_haz_wait",  64'(chk_hazard), 64'd1);
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
        step();
        req0_valid = 1'b0;
        check_eq("sb_wr_cycle",  64'(rf_wr),      64'd1);
        check_eq("sb_pend_wr",   64'(pending),    64'h80);
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd7;
        #1;
        check_eq("sb_haz_rs2",   64'(chk_hazard), 64'd1);
        step();
        check_eq("sb_pend_clr",  64'(pending),    64'h0);
        check_eq("sb_haz_clr",   64'(chk_hazard), 64'd0);
        chk_rs2 = 5'd0;

        // Set and clear of bit 9 at the same edge: set wins.
        issue_valid = 1'b1; issue_rd = 5'd9;
        req0_valid  = 1'b1; req0_rd  = 5'd9; req0_data = 32'h99;
        step();
        req0_valid = 1'b0;
        check_eq("sc_pend_9",    64'(pending),    64'h200);
        check_eq("sc_selwr",     64'(rf_selwr),   64'd9);
        step();                   // issue rd=9 still high during the rf_wr cycle
        issue_valid = 1'b0;
        check_eq("sc_set_wins",  64'(pending),    64'h200);
        step();
        check_eq("sc_hold",      64'(pending),    64'h200);

        // Build rf_wr=1 with pending=0x80, then assert reset mid-cycle.
        issue_valid = 1'b1; issue_rd = 5'd7;
        req0_valid  = 1'b1; req0_rd  = 5'd9; req0_data = 32'h90;
        step();
        issue_valid = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b1; req1_rd  = 5'd3; req1_data = 32'h33;
        step();
        req1_valid = 1'b0;
        check_eq("ar_pre_wr",    64'(rf_wr),      64'd1);
        check_eq("ar_pre_pend",  64'(pending),    64'h80);
        #1 rst = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
        #1;
        check_eq("ar_rf_wr",     64'(rf_wr),      64'd0);
        check_eq("ar_pending",   64'(pending),    64'd0);
        check_eq("ar_selwr",     64'(rf_selwr),   64'd0);
        check_eq("ar_ready0",    64'(req0_ready), 64'd0);
        check_eq("ar_ready1",    64'(req1_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("ar_first_g0",  64'(req0_ready), 64'd1);
        check_eq("ar_first_g1",  64'(req1_ready), 64'd0);
        step();
        check_eq("ar_first_sel", 64'(rf_selwr),   64'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass_r, n_checks_r);
        $finish;
    end

endmodule
